// File: rtl/mem_access.sv
// mem_access: memory-access stage of the 5-stage RV32I pipeline.
// Issues loads/stores over a valid/ready request channel, waits for the load
// response, aligns and extends load data into a register held for WB, and
// stalls upstream while an access is outstanding.
// Ports:
//   clock, reset              rising-edge clock, synchronous active-high reset
//   valid_in .. rs2_data_in   EX/ME pipeline register contents (held while stalled)
//   stall_out                 holds EX/ME and all upstream stages
//   dmem_req_*                request channel (valid/ready), word address + byte enables
//   dmem_rsp_*                load response channel
//   valid_out, *_out          completion strobe and pass-through fields to ME_WB
//   mem_res_out               registered, aligned load result
//   misaligned_out            completing access was misaligned or had an illegal funct3
module mem_access #(
  parameter logic [6:0] LOAD_OPCODE  = 7'b0000011,
  parameter logic [6:0] STORE_OPCODE = 7'b0100011
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [31:0] pc_in,
  input  logic [6:0]  opcode_in,
  input  logic [2:0]  funct3_in,
  input  logic [4:0]  rd_in,
  input  logic [31:0] alu_res_in,
  input  logic [31:0] rs2_data_in,
  output logic        stall_out,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_req_we,
  output logic [31:0] dmem_req_addr,
  output logic [31:0] dmem_req_wdata,
  output logic [3:0]  dmem_req_be,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rsp_rdata,
  output logic        valid_out,
  output logic [31:0] pc_out,
  output logic [6:0]  opcode_out,
  output logic [2:0]  funct3_out,
  output logic [4:0]  rd_out,
  output logic [31:0] alu_res_out,
  output logic [31:0] mem_res_out,
  output logic        misaligned_out
);

  typedef enum logic {IDLE, WAIT_RSP} state_t;

  state_t      state;
  state_t      next_state;
  logic        is_load;
  logic        is_store;
  logic        illegal_f3;
  logic        misaligned;
  logic        bad_access;
  logic        capture;
  logic [31:0] shifted;
  logic [31:0] load_data;

  // Pass-through fields to ME_WB
  assign pc_out      = pc_in;
  assign opcode_out  = opcode_in;
  assign funct3_out  = funct3_in;
  assign rd_out      = rd_in;
  assign alu_res_out = alu_res_in;

  assign is_load  = valid_in && (opcode_in == LOAD_OPCODE);
  assign is_store = valid_in && (opcode_in == STORE_OPCODE);

  // Illegal width/sign encodings: loads 3/6/7, stores 3 and above
  always_comb begin
    illegal_f3 = 1'b0;
    if (is_load)
      illegal_f3 = (funct3_in == 3'd3) || (funct3_in == 3'd6) || (funct3_in == 3'd7);
    else if (is_store)
      illegal_f3 = (funct3_in >= 3'd3);
  end

  // Alignment check keyed on access width (funct3[1:0])
  always_comb begin
    misaligned = 1'b0;
    case (funct3_in[1:0])
      2'b01:   misaligned = alu_res_in[0];
      2'b10:   misaligned = (alu_res_in[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  assign bad_access = illegal_f3 || misaligned;

  // Request fields; driven from held inputs so they stay stable while waiting for ready
  assign dmem_req_we   = is_store;
  assign dmem_req_addr = {alu_res_in[31:2], 2'b00};

  always_comb begin
    dmem_req_be    = 4'b1111;
    dmem_req_wdata = rs2_data_in;
    if (is_store) begin
      case (funct3_in[1:0])
        2'b00: begin
          dmem_req_be    = 4'(4'b0001 << alu_res_in[1:0]);
          dmem_req_wdata = {4{rs2_data_in[7:0]}};
        end
        2'b01: begin
          dmem_req_be    = alu_res_in[1] ? 4'b1100 : 4'b0011;
          dmem_req_wdata = {2{rs2_data_in[15:0]}};
        end
        default: begin
          dmem_req_be    = 4'b1111;
          dmem_req_wdata = rs2_data_in;
        end
      endcase
    end
  end

  // Load alignment: shift the addressed byte/half down to bit 0, then extend
  assign shifted = dmem_rsp_rdata >> {alu_res_in[1:0], 3'b000};

  always_comb begin
    case (funct3_in)
      3'd0:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'd1:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'd4:    load_data = {24'd0, shifted[7:0]};
      3'd5:    load_data = {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state and handshake/stall outputs
  always_comb begin
    next_state     = state;
    dmem_req_valid = 1'b0;
    stall_out      = 1'b0;
    valid_out      = 1'b0;
    misaligned_out = 1'b0;
    capture        = 1'b0;
    case (state)
      IDLE: begin
        if (!(is_load || is_store)) begin
          valid_out = valid_in;
        end else if (bad_access) begin
          valid_out      = 1'b1;
          misaligned_out = 1'b1;
        end else begin
          dmem_req_valid = 1'b1;
          if (!dmem_req_ready) begin
            stall_out = 1'b1;
          end else if (is_store) begin
            valid_out = 1'b1;
          end else begin
            stall_out  = 1'b1;
            next_state = WAIT_RSP;
          end
        end
      end
      WAIT_RSP: begin
        stall_out = 1'b1;
        if (dmem_rsp_valid) begin
          stall_out  = 1'b0;
          valid_out  = 1'b1;
          capture    = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Load result held for the WB cycle
  always_ff @(posedge clock) begin
    if (reset)        mem_res_out <= 32'd0;
    else if (capture) mem_res_out <= load_data;
  end

endmodule
